nvdla_partition_reset_seq: RTL and testbench

//  Reset sequencer for NVDLA core partitions, driven by the synchronized core reset.

---
 rtl/nvdla_partition_reset_seq.sv | 188 ++++++++++++++++++
 tb/tb_nvdla_partition_reset_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_partition_reset_seq.sv
// nvdla_partition_reset_seq
//   Reset sequencer for NVDLA core partitions.
//
//   After core reset is released, the per-partition resets are released one at a time,
//   GAP_CYC cycles apart, to limit inrush current. The block then serves software
//   soft-reset requests for single partitions: it asks the partition to quiesce, waits
//   for it to report idle, holds its reset low for HOLD_CYC cycles and releases it.
//   Concurrent requests are served in fixed priority, lowest index first.
//
//   Optional feature macro: NVDLA_RST_SEQ_TIMEOUT_EN
//     defined   : the quiesce wait is bounded by TIMEOUT_CYC cycles. On expiry the hold is
//                 forced and a sticky err_timeout bit is set for that partition.
//     undefined : the quiesce wait is unbounded and err_timeout is always 0.
//
// Ports
//   nvdla_core_clk   in   core clock
//   nvdla_core_rstn  in   async active-low reset, deassertion already synchronized
//   test_mode        in   DFT bypass: part_rstn follows nvdla_core_rstn, part_quiesce = 0
//   sw_rst_req       in   [NUM_PART] one-cycle soft-reset request pulses
//   part_idle        in   [NUM_PART] partition reports quiesced (level)
//   part_quiesce     out  [NUM_PART] ask partition to drain and stop (level)
//   part_rstn        out  [NUM_PART] per-partition active-low reset
//   seq_busy         out  sequencer not idle, or requests pending
//   seq_done         out  [NUM_PART] one-cycle one-hot pulse when a soft reset completes
//   err_timeout      out  [NUM_PART] sticky quiesce-timeout flags

module nvdla_partition_reset_seq #(
    parameter int NUM_PART    = 4,
    parameter int GAP_CYC     = 4,
    parameter int HOLD_CYC    = 8,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic                test_mode,
    input  logic [NUM_PART-1:0] sw_rst_req,
    input  logic [NUM_PART-1:0] part_idle,
    output logic [NUM_PART-1:0] part_quiesce,
    output logic [NUM_PART-1:0] part_rstn,
    output logic                seq_busy,
    output logic [NUM_PART-1:0] seq_done,
    output logic [NUM_PART-1:0] err_timeout
);

    localparam int IDX_W = (NUM_PART > 1) ? $clog2(NUM_PART) : 1;

`ifdef NVDLA_RST_SEQ_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    localparam logic [1:0] StInitRel = 2'd0;
    localparam logic [1:0] StIdle    = 2'd1;
    localparam logic [1:0] StQuiesce = 2'd2;
    localparam logic [1:0] StHold    = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;     // next partition to release in power-on sequence
    logic [IDX_W-1:0]    sel_q, sel_d;     // partition currently being served
    logic [IDX_W-1:0]    low_idx;
    logic [NUM_PART-1:0] pending_q, pending_d;
    logic [NUM_PART-1:0] rstn_q, rstn_d;
    logic [NUM_PART-1:0] quiesce_q, quiesce_d;
    logic [NUM_PART-1:0] done_q, done_d;
    logic [NUM_PART-1:0] err_q, err_d;
    logic                busy_q, busy_d;
    logic                timeout_hit;

    // Fixed priority: lowest pending index wins.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_PART - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign timeout_hit = TimeoutEn && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        pending_d = pending_q;
        rstn_d    = rstn_q;
        quiesce_d = quiesce_q;
        done_d    = '0;
        err_d     = err_q;
        // Registered from current state, so busy drops one cycle after entering idle.
        busy_d    = (state_q != StIdle) || (pending_q != '0);

        case (state_q)
            StInitRel: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d         = '0;
                    rstn_d[idx_q] = 1'b1;
                    if (idx_q == IDX_W'(NUM_PART - 1)) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (pending_q != '0) begin
                    sel_d              = low_idx;
                    quiesce_d[low_idx] = 1'b1;
                    cnt_d              = '0;
                    state_d            = StQuiesce;
                end
            end
            StQuiesce: begin
                if (part_idle[sel_q] || timeout_hit) begin
                    quiesce_d[sel_q] = 1'b0;
                    rstn_d[sel_q]    = 1'b0;
                    pending_d[sel_q] = 1'b0;
                    cnt_d            = '0;
                    state_d          = StHold;
                    if (!part_idle[sel_q]) begin
                        err_d[sel_q] = 1'b1;
                    end
                end else if (TimeoutEn) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin // StHold
                if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                    rstn_d[sel_q] = 1'b1;
                    done_d[sel_q] = 1'b1;
                    cnt_d         = '0;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        // Merge new requests after the service clear so a request on the clearing edge
        // is not lost.
        pending_d = pending_d | sw_rst_req;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q   <= StInitRel;
            cnt_q     <= '0;
            idx_q     <= '0;
            sel_q     <= '0;
            pending_q <= '0;
            rstn_q    <= '0;
            quiesce_q <= '0;
            done_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            pending_q <= pending_d;
            rstn_q    <= rstn_d;
            quiesce_q <= quiesce_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // DFT bypass is the only combinational path to the outputs.
    assign part_rstn    = test_mode ? {NUM_PART{nvdla_core_rstn}} : rstn_q;
    assign part_quiesce = test_mode ? '0 : quiesce_q;
    assign seq_busy     = busy_q;
    assign seq_done     = done_q;

`ifdef NVDLA_RST_SEQ_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = '0;
`endif

endmodule

// File: tb/tb_nvdla_partition_reset_seq.sv
module tb_nvdla_partition_reset_seq;

    logic       clk;
    logic       rstn;
    logic       test_mode;
    logic [3:0] sw_rst_req;
    logic [3:0] part_idle;
    logic [3:0] part_quiesce;
    logic [3:0] part_rstn;
    logic       seq_busy;
    logic [3:0] seq_done;
    logic [3:0] err_timeout;

    int checks = 0;
    int errors = 0;

    nvdla_partition_reset_seq dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .test_mode      (test_mode),
        .sw_rst_req     (sw_rst_req),
        .part_idle      (part_idle),
        .part_quiesce   (part_quiesce),
        .part_rstn      (part_rstn),
        .seq_busy       (seq_busy),
        .seq_done       (seq_done),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Next posedge after this task is power-on cycle 1.
    task automatic do_reset;
        rstn       = 1'b0;
        test_mode  = 1'b0;
        sw_rst_req = '0;
        part_idle  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        logic [3:0] exp_r;
        bit         exp_b;
        rstn       = 1'b0;
        test_mode  = 1'b0;
        sw_rst_req = '0;
        part_idle  = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (part_rstn !== 4'b0000) begin errors++; $display("FAIL rst_part_rstn got %b exp 0000", part_rstn); end
        checks++; if (part_quiesce !== 4'b0000) begin errors++; $display("FAIL rst_quiesce got %b exp 0000", part_quiesce); end
        checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", seq_busy); end
        checks++; if (seq_done !== 4'b0000) begin errors++; $display("FAIL rst_done got %b exp 0000", seq_done); end
        checks++; if (err_timeout !== 4'b0000) begin errors++; $display("FAIL rst_err got %b exp 0000", err_timeout); end
        @(negedge clk);
        rstn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            for (int k = 0; k < 4; k++) exp_r[k] = (e >= 4 * (k + 1));
            exp_b = (e < 17);
            checks++; if (part_rstn !== exp_r) begin errors++; $display("FAIL init_rstn cyc %0d got %b exp %b", e, part_rstn, exp_r); end
            checks++; if (seq_busy !== exp_b) begin errors++; $display("FAIL init_busy cyc %0d got %b exp %b", e, seq_busy, exp_b); end
        end
    endtask

    task automatic test_single;
        int low_cnt = 0, done_cnt = 0;
        bit others_ok = 1, rise_done = 0, bad_done = 0;
        logic prev_r;
        sw_rst_req = 4'b0010;
        tick();
        sw_rst_req = '0;
        checks++; if (part_quiesce !== 4'b0000) begin errors++; $display("FAIL single_q_early got %b exp 0000", part_quiesce); end
        tick();
        checks++; if (part_quiesce !== 4'b0010) begin errors++; $display("FAIL single_q got %b exp 0010", part_quiesce); end
        checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", seq_busy); end
        tick();
        tick();
        part_idle = 4'b0010;
        prev_r = part_rstn[1];
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) begin
                checks++; if ({part_rstn, part_quiesce} !== 8'b1101_0000) begin errors++; $display("FAIL single_hold got r=%b q=%b exp r=1101 q=0000", part_rstn, part_quiesce); end
                part_idle = '0;
            end
            if (!part_rstn[1]) low_cnt++;
            if (seq_done == 4'b0010) done_cnt++;
            else if (seq_done != 4'b0000) bad_done = 1;
            if (!prev_r && part_rstn[1] && seq_done == 4'b0010) rise_done = 1;
            if ({part_rstn[3:2], part_rstn[0]} != 3'b111) others_ok = 0;
            prev_r = part_rstn[1];
        end
        checks++; if (low_cnt != 8) begin errors++; $display("FAIL single_low got %0d exp 8", low_cnt); end
        checks++; if (done_cnt != 1 || bad_done) begin errors++; $display("FAIL single_done got %0d bad=%0d exp 1 bad=0", done_cnt, bad_done); end
        checks++; if (!rise_done) begin errors++; $display("FAIL single_done_at_rise got 0 exp 1"); end
        checks++; if (!others_ok) begin errors++; $display("FAIL single_others got 0 exp 1"); end
        checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", seq_busy); end
    endtask

    task automatic test_two;
        int ndone = 0, low0 = 0, low3 = 0, done0_at = -1, q3_at = -1;
        logic [3:0] d0 = '0, d1 = '0;
        bit others_ok = 1, onehot_ok = 1;
        sw_rst_req = 4'b1001;
        tick();
        sw_rst_req = '0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (seq_done != 4'b0000) begin
                if (ndone == 0) begin d0 = seq_done; done0_at = i; end
                else if (ndone == 1) d1 = seq_done;
                ndone++;
            end
            if (part_quiesce[3] && q3_at < 0) q3_at = i;
            if (!part_rstn[0]) low0++;
            if (!part_rstn[3]) low3++;
            if (part_rstn[2:1] != 2'b11) others_ok = 0;
            if (part_quiesce != 0 && part_quiesce != 4'b0001 && part_quiesce != 4'b1000) onehot_ok = 0;
            part_idle = part_quiesce;
        end
        part_idle = '0;
        checks++; if (ndone != 2) begin errors++; $display("FAIL two_ndone got %0d exp 2", ndone); end
        checks++; if (d0 !== 4'b0001 || d1 !== 4'b1000) begin errors++; $display("FAIL two_order got %b,%b exp 0001,1000", d0, d1); end
        checks++; if (low0 != 8 || low3 != 8) begin errors++; $display("FAIL two_low got %0d,%0d exp 8,8", low0, low3); end
        checks++; if (q3_at - done0_at != 1) begin errors++; $display("FAIL two_gap got %0d exp 1", q3_at - done0_at); end
        checks++; if (!others_ok || !onehot_ok) begin errors++; $display("FAIL two_others got %0d%0d exp 11", others_ok, onehot_ok); end
    endtask

    task automatic test_hold_repeat;
        int ndone = 0, low = 0, run = 0, qrise = 0;
        bit fired = 0;
        logic prev_q = 1'b0;
        sw_rst_req = 4'b0010;
        tick();
        sw_rst_req = '0;
        for (int i = 0; i < 60; i++) begin
            tick();
            sw_rst_req = '0;
            if (seq_done == 4'b0010) ndone++;
            if (part_quiesce[1] && !prev_q) qrise++;
            prev_q = part_quiesce[1];
            if (!part_rstn[1]) begin low++; run++; end else run = 0;
            if (run == 3 && !fired) begin sw_rst_req = 4'b0010; fired = 1; end
            part_idle = part_quiesce;
        end
        part_idle = '0;
        checks++; if (ndone != 2) begin errors++; $display("FAIL repeat_ndone got %0d exp 2", ndone); end
        checks++; if (low != 16) begin errors++; $display("FAIL repeat_low got %0d exp 16", low); end
        checks++; if (qrise != 2) begin errors++; $display("FAIL repeat_qrise got %0d exp 2", qrise); end
    endtask

    task automatic test_init_req;
        bit q_early = 0, hold_ok = 1;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            tick();
            sw_rst_req = (e == 5) ? 4'b0100 : 4'b0000;
            if (e <= 16 && part_quiesce != 0) q_early = 1;
            if (e == 16) begin
                checks++; if (part_rstn !== 4'b1111) begin errors++; $display("FAIL initreq_rel got %b exp 1111", part_rstn); end
            end
            if (e == 17) begin
                checks++; if (part_quiesce !== 4'b0100) begin errors++; $display("FAIL initreq_q got %b exp 0100", part_quiesce); end
            end
            if (e >= 18 && e <= 25 && part_rstn !== 4'b1011) hold_ok = 0;
            if (e == 26) begin
                checks++; if ({part_rstn, seq_done} !== 8'b1111_0100) begin errors++; $display("FAIL initreq_done got r=%b d=%b exp r=1111 d=0100", part_rstn, seq_done); end
            end
            part_idle = part_quiesce;
        end
        part_idle = '0;
        checks++; if (q_early) begin errors++; $display("FAIL initreq_early got 1 exp 0"); end
        checks++; if (!hold_ok) begin errors++; $display("FAIL initreq_hold got 0 exp 1"); end
    endtask

`ifdef NVDLA_RST_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int qcnt = 0;
        bit fell = 0;
        logic [3:0] err_at = '0;
        part_idle  = '0;
        sw_rst_req = 4'b0100;
        tick();
        sw_rst_req = '0;
        for (int i = 0; i < 100 && !fell; i++) begin
            tick();
            if (!part_rstn[2]) begin fell = 1; err_at = err_timeout; end
            else if (part_quiesce[2]) qcnt++;
        end
        checks++; if (!fell || qcnt != 64) begin errors++; $display("FAIL tmo_len got fell=%0d q=%0d exp 1,64", fell, qcnt); end
        checks++; if (err_at !== 4'b0100) begin errors++; $display("FAIL tmo_err got %b exp 0100", err_at); end
        tick(); tick();
        #2 rstn = 1'b0;
        #1;
        checks++; if ({part_rstn, part_quiesce, seq_done, err_timeout, seq_busy} !== 17'h0_0001) begin errors++; $display("FAIL tmo_async got r=%b q=%b d=%b e=%b b=%b exp 0,0,0,0,1", part_rstn, part_quiesce, seq_done, err_timeout, seq_busy); end
        do_reset();
        repeat (20) tick();
    endtask
`else
    task automatic test_no_timeout;
        bit seen = 0;
        part_idle  = '0;
        sw_rst_req = 4'b0100;
        tick();
        sw_rst_req = '0;
        repeat (100) tick();
        checks++; if ({part_quiesce, part_rstn, err_timeout, seq_busy} !== 13'b0100_1111_0000_1) begin errors++; $display("FAIL notmo_wait got q=%b r=%b e=%b b=%b exp 0100,1111,0000,1", part_quiesce, part_rstn, err_timeout, seq_busy); end
        part_idle = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            tick();
            part_idle = '0;
            if (seq_done == 4'b0100) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL notmo_done got 0 exp 1"); end
    endtask
`endif

    task automatic test_mode_bypass;
        sw_rst_req = 4'b0001;
        tick();
        sw_rst_req = '0;
        tick();
        test_mode = 1'b1;
        #1;
        checks++; if ({part_quiesce, part_rstn} !== 8'b0000_1111) begin errors++; $display("FAIL tm_force got q=%b r=%b exp 0000,1111", part_quiesce, part_rstn); end
        tick(); tick();
        test_mode = 1'b0;
        #1;
        checks++; if (part_quiesce !== 4'b0001) begin errors++; $display("FAIL tm_fsm got %b exp 0001", part_quiesce); end
        test_mode = 1'b1;
        rstn = 1'b0;
        #1;
        checks++; if (part_rstn !== 4'b0000) begin errors++; $display("FAIL tm_rstn got %b exp 0000", part_rstn); end
        test_mode = 1'b0;
    endtask

    task automatic test_async_reset;
        do_reset();
        repeat (20) tick();
        sw_rst_req = 4'b1000;
        tick();
        sw_rst_req = '0;
        tick();
        part_idle = 4'b1000;
        tick();
        part_idle = '0;
        tick(); tick();
        checks++; if (part_rstn !== 4'b0111) begin errors++; $display("FAIL arst_pre got %b exp 0111", part_rstn); end
        #3 rstn = 1'b0;
        #1;
        checks++; if ({part_rstn, part_quiesce, seq_done, err_timeout, seq_busy} !== 17'h0_0001) begin errors++; $display("FAIL arst got r=%b q=%b d=%b e=%b b=%b exp 0,0,0,0,1", part_rstn, part_quiesce, seq_done, err_timeout, seq_busy); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) tick();
        checks++; if ({part_rstn, part_quiesce, seq_busy} !== 9'b1111_0000_0) begin errors++; $display("FAIL arst_lost got r=%b q=%b b=%b exp 1111,0000,0", part_rstn, part_quiesce, seq_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_hold_repeat();
        test_init_req();
`ifdef NVDLA_RST_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_mode_bypass();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
